// File: rtl/subcode_pkg.sv
// Shared types and constants for the subcode deserialiser: FSM states,
// Q-channel CRC constants and the CRC-16 step used when SUBCODE_QCRC_EN is defined.
package subcode_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        PUSH = 2'd3
    } subcode_state_e;

    localparam logic [15:0] QCRC_POLY  = 16'h1021;
    localparam int          QBITS      = 96;
    localparam int          QDATA_BITS = 80;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic data_bit);
        logic fb;
        fb = crc[15] ^ data_bit;
        return {crc[14:0], 1'b0} ^ (fb ? QCRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/subcode_fifo.sv
// Show-ahead synchronous FIFO with flush, fill level and full/empty flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module subcode_fifo #(
    parameter int DW    = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          do_pop_s;
    logic          do_push_s;

    assign do_pop_s  = pop & (level_r != {(AW+1){1'b0}});
    assign do_push_s = push & ((level_r != FULL_LVL) | do_pop_s);

    assign dout  = mem_r[rd_ptr_r];
    assign empty = (level_r == {(AW+1){1'b0}});
    assign full  = (level_r == FULL_LVL);
    assign level = level_r;

    // Storage, pointers and fill level; flush drops any simultaneous push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/subcode_deserializer.sv
// CD subcode deserialiser: SCCK burst per EFFK frame, WIDTH-bit shifter and tagged FIFO.
// Define SUBCODE_QCRC_EN to add the Q-channel CRC checker (QCRC_OK / QCRC_ERR).
module subcode_deserializer
    import subcode_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int SCCK_DIV    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    CDAC,
    input  logic                    IFRST_n,
    input  logic                    EFFK,
    input  logic                    SCOR,
    input  logic                    SBCP,
    output logic                    SCCK,
    input  logic                    RD,
    input  logic                    CLR,
    output logic [WIDTH-1:0]        SUBQ,
    output logic                    SYNC,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic                    OVF
`ifdef SUBCODE_QCRC_EN
    ,
    output logic                    QCRC_OK,
    output logic                    QCRC_ERR
`endif
);
    localparam int DCW = $clog2(SCCK_DIV + 1);
    localparam int BCW = $clog2(WIDTH + 1);

    typedef struct packed {
        logic             sync;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [1:0]             rst_sync_r;
    logic                   rst_n_s;
    logic [SYNC_STAGES-1:0] effk_sync_r;
    logic [SYNC_STAGES-1:0] scor_sync_r;
    logic [SYNC_STAGES-1:0] sbcp_sync_r;
    logic                   effk_prev_r;
    logic                   scor_prev_r;
    logic                   effk_edge_s;
    logic                   scor_edge_s;
    logic                   sbcp_s;

    subcode_state_e         state_r;
    subcode_state_e         state_nxt;
    logic [DCW-1:0]         div_r;
    logic [DCW-1:0]         div_nxt;
    logic [BCW-1:0]         bit_r;
    logic [BCW-1:0]         bit_nxt;
    logic [WIDTH-1:0]       shift_r;
    logic [WIDTH-1:0]       shift_nxt;
    logic                   push_s;
    logic                   tag_s;
    logic                   pend_sync_r;
    logic                   scck_r;
    logic                   ovf_r;
    entry_t                 wr_entry_s;
    entry_t                 rd_entry_s;

    // Reset release synchroniser: assertion is immediate, release follows CDAC.
    always_ff @(posedge CDAC or negedge IFRST_n) begin
        if (!IFRST_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    // Input synchronisers and edge-history flops for the drive signals.
    always_ff @(posedge CDAC or negedge rst_n_s) begin
        if (!rst_n_s) begin
            effk_sync_r <= {SYNC_STAGES{1'b0}};
            scor_sync_r <= {SYNC_STAGES{1'b0}};
            sbcp_sync_r <= {SYNC_STAGES{1'b0}};
            effk_prev_r <= 1'b0;
            scor_prev_r <= 1'b0;
        end else begin
            effk_sync_r <= {effk_sync_r[SYNC_STAGES-2:0], EFFK};
            scor_sync_r <= {scor_sync_r[SYNC_STAGES-2:0], SCOR};
            sbcp_sync_r <= {sbcp_sync_r[SYNC_STAGES-2:0], SBCP};
            effk_prev_r <= effk_sync_r[SYNC_STAGES-1];
            scor_prev_r <= scor_sync_r[SYNC_STAGES-1];
        end
    end

    assign effk_edge_s = effk_sync_r[SYNC_STAGES-1] & ~effk_prev_r;
    assign scor_edge_s = scor_sync_r[SYNC_STAGES-1] & ~scor_prev_r;
    assign sbcp_s      = sbcp_sync_r[SYNC_STAGES-1];

    // Burst sequencer: next state, divider, bit counter and shifter.
    always_comb begin
        state_nxt = state_r;
        div_nxt   = div_r;
        bit_nxt   = bit_r;
        shift_nxt = shift_r;
        push_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (effk_edge_s) begin
                    state_nxt = HIGH;
                    div_nxt   = {DCW{1'b0}};
                    bit_nxt   = {BCW{1'b0}};
                end else begin
                    state_nxt = IDLE;
                end
            end
            HIGH: begin
                if (div_r == DCW'(SCCK_DIV - 1)) begin
                    div_nxt   = {DCW{1'b0}};
                    shift_nxt = {shift_r[WIDTH-2:0], sbcp_s};
                    state_nxt = LOW;
                end else begin
                    div_nxt = div_r + {{(DCW-1){1'b0}}, 1'b1};
                end
            end
            LOW: begin
                if (div_r == DCW'(SCCK_DIV - 1)) begin
                    div_nxt = {DCW{1'b0}};
                    if (bit_r == BCW'(WIDTH - 1)) begin
                        state_nxt = PUSH;
                    end else begin
                        bit_nxt   = bit_r + {{(BCW-1){1'b0}}, 1'b1};
                        state_nxt = HIGH;
                    end
                end else begin
                    div_nxt = div_r + {{(DCW-1){1'b0}}, 1'b1};
                end
            end
            PUSH: begin
                push_s    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state register; SCCK is registered from the next state.
    always_ff @(posedge CDAC or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= IDLE;
            div_r   <= {DCW{1'b0}};
            bit_r   <= {BCW{1'b0}};
            shift_r <= {WIDTH{1'b0}};
            scck_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            div_r   <= div_nxt;
            bit_r   <= bit_nxt;
            shift_r <= shift_nxt;
            scck_r  <= (state_nxt == HIGH);
        end
    end

    // A SCOR edge coinciding with PUSH tags the word being written.
    assign tag_s = pend_sync_r | scor_edge_s;

    // Pending-sync flag and sticky overflow.
    always_ff @(posedge CDAC or negedge rst_n_s) begin
        if (!rst_n_s) begin
            pend_sync_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            if (push_s) begin
                pend_sync_r <= 1'b0;
            end else if (scor_edge_s) begin
                pend_sync_r <= 1'b1;
            end else begin
                pend_sync_r <= pend_sync_r;
            end
            if (CLR) begin
                ovf_r <= 1'b0;
            end else if (push_s && FULL && !(RD && !EMPTY)) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign wr_entry_s = '{sync: tag_s, data: shift_r};

    subcode_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CDAC),
        .rst_n (rst_n_s),
        .clr   (CLR),
        .push  (push_s),
        .pop   (RD),
        .din   (wr_entry_s),
        .dout  (rd_entry_s),
        .empty (EMPTY),
        .full  (FULL),
        .level (LEVEL)
    );

    assign SCCK = scck_r;
    assign SUBQ = rd_entry_s.data;
    assign SYNC = rd_entry_s.sync;
    assign OVF  = ovf_r;

`ifdef SUBCODE_QCRC_EN
    logic [6:0]  q_cnt_r;
    logic        q_act_r;
    logic        q_bad_r;
    logic [15:0] crc_r;
    logic        qcrc_ok_r;
    logic        qcrc_err_r;
    logic        q_bit_s;
    logic        q_miss_s;
    logic [3:0]  crc_idx_s;

    // q_cnt counts symbols since the tagged S0: 2..81 carry data, 82..97 the inverted CRC.
    assign q_bit_s   = shift_r[WIDTH-2];
    assign crc_idx_s = 4'(7'(QBITS + 1) - q_cnt_r);
    assign q_miss_s  = (q_bit_s != ~crc_r[crc_idx_s]);

    // Q-channel CRC tracker driven by every word the sequencer pushes.
    always_ff @(posedge CDAC or negedge rst_n_s) begin
        if (!rst_n_s) begin
            q_cnt_r    <= 7'd0;
            q_act_r    <= 1'b0;
            q_bad_r    <= 1'b0;
            crc_r      <= 16'h0000;
            qcrc_ok_r  <= 1'b0;
            qcrc_err_r <= 1'b0;
        end else begin
            qcrc_ok_r  <= 1'b0;
            qcrc_err_r <= 1'b0;
            if (push_s && tag_s) begin
                q_act_r <= 1'b1;
                q_cnt_r <= 7'd1;
                q_bad_r <= 1'b0;
                crc_r   <= 16'h0000;
            end else if (push_s && q_act_r) begin
                q_cnt_r <= q_cnt_r + 7'd1;
                if (q_cnt_r >= 7'd2 && q_cnt_r < 7'(2 + QDATA_BITS)) begin
                    crc_r <= crc16_step(crc_r, q_bit_s);
                end else if (q_cnt_r == 7'(QBITS + 1)) begin
                    q_act_r    <= 1'b0;
                    qcrc_ok_r  <= ~(q_bad_r | q_miss_s);
                    qcrc_err_r <= q_bad_r | q_miss_s;
                end else if (q_cnt_r >= 7'(2 + QDATA_BITS)) begin
                    q_bad_r <= q_bad_r | q_miss_s;
                end else begin
                    crc_r <= crc_r;
                end
            end else begin
                q_act_r <= q_act_r;
            end
        end
    end

    assign QCRC_OK  = qcrc_ok_r;
    assign QCRC_ERR = qcrc_err_r;
`endif

endmodule

// File: tb/tb_subcode_deserializer.sv
// Directed self-checking bench for subcode_deserializer (default and WIDTH=6/SCCK_DIV=1 builds).
// Q-channel CRC checks are included when SUBCODE_QCRC_EN is defined.
module tb_subcode_deserializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       effk_a = 1'b0, effk_b = 1'b0, scor = 1'b0, sbcp = 1'b0;
    logic       rd_a = 1'b0, rd_b = 1'b0, clr = 1'b0;
    logic       scck_a, scck_b, sync_a, sync_b, empty_a, empty_b, full_a, full_b, ovf_a, ovf_b;
    logic [7:0] subq_a;
    logic [5:0] subq_b;
    logic [4:0] level_a, level_b;
    int         checks = 0;
    int         failures = 0;
`ifdef SUBCODE_QCRC_EN
    logic       qok_a, qerr_a, qok_b, qerr_b;
    int         ok_cnt = 0;
    int         err_cnt = 0;
`endif

    always #5 clk = ~clk;

    subcode_deserializer dut_a (
        .CDAC(clk), .IFRST_n(rst_n), .EFFK(effk_a), .SCOR(scor), .SBCP(sbcp),
        .SCCK(scck_a), .RD(rd_a), .CLR(clr), .SUBQ(subq_a), .SYNC(sync_a),
        .EMPTY(empty_a), .FULL(full_a), .LEVEL(level_a), .OVF(ovf_a)
`ifdef SUBCODE_QCRC_EN
        , .QCRC_OK(qok_a), .QCRC_ERR(qerr_a)
`endif
    );

    subcode_deserializer #(.WIDTH(6), .SCCK_DIV(1)) dut_b (
        .CDAC(clk), .IFRST_n(rst_n), .EFFK(effk_b), .SCOR(1'b0), .SBCP(sbcp),
        .SCCK(scck_b), .RD(rd_b), .CLR(clr), .SUBQ(subq_b), .SYNC(sync_b),
        .EMPTY(empty_b), .FULL(full_b), .LEVEL(level_b), .OVF(ovf_b)
`ifdef SUBCODE_QCRC_EN
        , .QCRC_OK(qok_b), .QCRC_ERR(qerr_b)
`endif
    );

`ifdef SUBCODE_QCRC_EN
    always @(negedge clk) begin
        if (qok_a) ok_cnt++;
        if (qerr_a) err_cnt++;
    end
`endif

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic pop_a();
        @(negedge clk) rd_a = 1'b1;
        @(negedge clk) rd_a = 1'b0;
    endtask

    task automatic flush();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic scor_pulse();
        @(negedge clk) scor = 1'b1;
        repeat (4) @(negedge clk);
        scor = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // One EFFK frame; the drive presents the next bit right after each SCCK rise.
    task automatic run_frame(input int sel, input logic [7:0] data, input bit chk,
                             input bit repulse, input bit rd_push);
        int w, d, pulses, hi_len, lo_len, first_hi, lat;
        bit prev, cur, bad;
        logic [4:0] lvl0, lvl;
        w = (sel != 0) ? 6 : 8;
        d = (sel != 0) ? 1 : 2;
        pulses = 0; hi_len = 0; lo_len = 0; first_hi = -1; lat = -1;
        prev = 1'b0; bad = 1'b0;
        lvl0 = (sel != 0) ? level_b : level_a;
        sbcp = data[w-1];
        if (sel != 0) effk_b = 1'b1; else effk_a = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(negedge clk);
            rd_a = 1'b0;
            if (cyc == 4) begin effk_a = 1'b0; effk_b = 1'b0; end
            if (repulse && first_hi >= 0 && cyc == first_hi + 6) effk_a = 1'b1;
            if (repulse && first_hi >= 0 && cyc == first_hi + 10) effk_a = 1'b0;
            cur = (sel != 0) ? scck_b : scck_a;
            lvl = (sel != 0) ? level_b : level_a;
            if (cur && !prev) begin
                if (pulses > 0 && lo_len != d) bad = 1'b1;
                pulses++;
                if (pulses == 1) first_hi = cyc;
                if (pulses < w) sbcp = data[w-1-pulses];
                hi_len = 0;
            end
            if (!cur && prev) begin
                if (hi_len != d) bad = 1'b1;
                lo_len = 0;
            end
            if (cur) hi_len++; else lo_len++;
            if (rd_push && pulses == w && !cur && lo_len == d + 1) rd_a = 1'b1;
            if (lat < 0 && first_hi >= 0 && lvl != lvl0) lat = cyc - first_hi;
            prev = cur;
        end
        check_eq("pulse_count", pulses, w);
        if (chk) begin
            check_eq("pulse_widths_ok", {31'd0, ~bad}, 32'd1);
            check_eq("frame_latency", lat, w * 2 * d + 1);
        end
    endtask

`ifdef SUBCODE_QCRC_EN
    task automatic run_qblock(input bit flip);
        logic        qd [80];
        logic [15:0] crc, nc;
        logic        q, fb;
        crc = 16'h0000;
        for (int i = 0; i < 80; i++) begin
            qd[i] = (((i * 5 + 3) % 7) < 3);
            fb = crc[15] ^ qd[i];
            nc = {crc[14:0], 1'b0};
            crc = fb ? (nc ^ 16'h1021) : nc;
        end
        scor_pulse();
        for (int f = 0; f < 98; f++) begin
            if (f < 2) q = 1'b0;
            else if (f < 82) q = qd[f-2] ^ (flip && f == 40);
            else q = ~crc[15-(f-82)];
            run_frame(0, {1'b0, q, 6'h15}, 1'b0, 1'b0, 1'b0);
            pop_a();
        end
    endtask
`endif

    initial begin
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_scck", scck_a, 1'b0);
        check_eq("rst_subq", subq_a, 8'h00);
        check_eq("rst_flags", {sync_a, empty_a, full_a, ovf_a}, 4'b0100);
        check_eq("rst_level", level_a, 5'd0);

        run_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        check_eq("a5_subq", subq_a, 8'hA5);
        check_eq("a5_sync", sync_a, 1'b0);
        check_eq("a5_level", level_a, 5'd1);
        pop_a();
        check_eq("a5_popped_empty", empty_a, 1'b1);

        scor_pulse();
        run_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_frame(0, 8'h01, 1'b0, 1'b0, 1'b0);
        check_eq("scor_head", {sync_a, subq_a}, {1'b1, 8'h3C});
        check_eq("scor_level", level_a, 5'd2);
        pop_a();
        check_eq("scor_second", {sync_a, subq_a}, {1'b0, 8'h01});

        flush();
        for (int i = 0; i < 16; i++) run_frame(0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        check_eq("fill_full", {full_a, ovf_a}, 2'b10);
        check_eq("fill_level", level_a, 5'd16);
        run_frame(0, 8'h30, 1'b0, 1'b0, 1'b0);
        check_eq("ovf_set", ovf_a, 1'b1);
        check_eq("ovf_level", level_a, 5'd16);
        check_eq("ovf_head", subq_a, 8'h10);

        flush();
        check_eq("clr_state", {ovf_a, empty_a, level_a}, {1'b0, 1'b1, 5'd0});
        for (int i = 0; i < 16; i++) run_frame(0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        run_frame(0, 8'h30, 1'b0, 1'b0, 1'b1);
        check_eq("rdpush_ovf", ovf_a, 1'b0);
        check_eq("rdpush_level", level_a, 5'd16);
        check_eq("rdpush_head", subq_a, 8'h11);
        for (int i = 0; i < 15; i++) pop_a();
        check_eq("rdpush_tail", subq_a, 8'h30);

        flush();
        run_frame(0, 8'h96, 1'b1, 1'b1, 1'b0);
        check_eq("repulse_level", level_a, 5'd1);
        check_eq("repulse_subq", subq_a, 8'h96);

        // Reset asserted during the fourth SCCK pulse.
        begin
            int  np;
            bit  pv;
            np = 0; pv = 1'b0;
            @(negedge clk) effk_a = 1'b1;
            for (int cyc = 0; cyc < 80 && np < 4; cyc++) begin
                @(negedge clk);
                if (cyc == 4) effk_a = 1'b0;
                if (scck_a && !pv) np++;
                pv = scck_a;
            end
            effk_a = 1'b0;
            check_eq("rst_mid_reached4", np, 4);
            rst_n = 1'b0;
            #1;
            check_eq("rst_mid_scck", scck_a, 1'b0);
            check_eq("rst_mid_empty", empty_a, 1'b1);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (60) @(negedge clk);
            check_eq("rst_mid_noword", {empty_a, level_a}, {1'b1, 5'd0});
        end

        run_frame(1, 8'b0010_1011, 1'b1, 1'b0, 1'b0);
        check_eq("w6_subq", subq_b, 6'b101011);
        check_eq("w6_sync_level", {sync_b, level_b}, {1'b0, 5'd1});

`ifdef SUBCODE_QCRC_EN
        flush();
        run_qblock(1'b0);
        check_eq("qcrc_ok_pulses", ok_cnt, 1);
        check_eq("qcrc_err_none", err_cnt, 0);
        run_qblock(1'b1);
        check_eq("qcrc_err_pulses", err_cnt, 1);
        check_eq("qcrc_ok_unchanged", ok_cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
